addr_decode_sched: RTL

Shares one rule-based address decoder among `NoReq` requesters. Each cycle it round-robin-grants one valid request, matches its address against an active rule map, and returns the decoded index in a one-entry registered response slot. It also owns a software-programmable shadow map, which it commits to the active map only when no decode is in flight. It sits between the master-side request ports and the crossbar demux select logic.

---
 rtl/addr_decode_sched.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/addr_decode_sched.sv
`default_nettype none
// ============================================================================
// Module   : addr_decode_sched
// Purpose  : Shares one rule-based address decoder among NoReq requesters.
//            A round-robin arbiter grants one valid request per cycle. The
//            winner's address is matched against the active rule map. The
//            result goes into a one-entry registered response slot.
//            A software-written shadow map is copied to the active map only
//            after the slot has drained, so a response always carries the
//            map that was active when it was granted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   req_valid_i / req_ready_o : per-requester request / one-hot grant
//   req_addr_i                : per-requester address
//   rsp_valid_o / rsp_ready_i : response slot handshake
//   rsp_req_o                 : requester the response belongs to
//   rsp_idx_o, rsp_error_o    : decoded index, no-match error
//   cfg_valid_i / cfg_ready_o : shadow rule write handshake
//   cfg_rule_i, cfg_idx_i     : rule slot and target index
//   cfg_start_i, cfg_end_i    : rule range [start, end)
//   cfg_commit_i              : request shadow -> active copy
//   en_default_idx_i          : map unmatched addresses to default_idx_i
//   default_idx_i             : default index
// Build option
//   ADDR_DECODE_SCHED_DEFAULT_IDX_EN : enables default-index mapping; when
//   undefined, unmatched addresses always return idx 0 with error set.
// ============================================================================
module addr_decode_sched #(
    parameter  int NoReq     = 4,
    parameter  int NoIndices = 2,
    parameter  int NoRules   = 3,
    parameter  int AddrWidth = 12,
    localparam int ReqW      = $clog2(NoReq),
    localparam int IdxW      = (NoIndices > 1) ? $clog2(NoIndices) : 1,
    localparam int RuleW     = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NoReq-1:0]                req_valid_i,
    output logic [NoReq-1:0]                req_ready_o,
    input  logic [NoReq-1:0][AddrWidth-1:0] req_addr_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [ReqW-1:0]                 rsp_req_o,
    output logic [IdxW-1:0]                 rsp_idx_o,
    output logic                            rsp_error_o,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [RuleW-1:0]                cfg_rule_i,
    input  logic [IdxW-1:0]                 cfg_idx_i,
    input  logic [AddrWidth-1:0]            cfg_start_i,
    input  logic [AddrWidth-1:0]            cfg_end_i,
    input  logic                            cfg_commit_i,
    input  logic                            en_default_idx_i,
    input  logic [IdxW-1:0]                 default_idx_i
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e               state_q;
    logic                 cfg_ready_q;
    logic [ReqW-1:0]      rr_q;
    logic                 rsp_valid_q;
    logic [ReqW-1:0]      rsp_req_q;
    logic [IdxW-1:0]      rsp_idx_q;
    logic                 rsp_error_q;

    logic [AddrWidth-1:0] shd_start_q [NoRules];
    logic [AddrWidth-1:0] shd_end_q   [NoRules];
    logic [IdxW-1:0]      shd_idx_q   [NoRules];
    logic [AddrWidth-1:0] act_start_q [NoRules];
    logic [AddrWidth-1:0] act_end_q   [NoRules];
    logic [IdxW-1:0]      act_idx_q   [NoRules];

    logic                 w_pop;
    logic                 w_slot_free;
    logic                 w_can_grant;
    logic                 w_found;
    logic [ReqW-1:0]      w_cand;
    logic [ReqW-1:0]      w_winner;
    logic [NoReq-1:0]     w_grant;
    logic [ReqW-1:0]      rr_d;
    logic [AddrWidth-1:0] w_addr;
    logic                 w_hit;
    logic [IdxW-1:0]      w_hit_idx;
    logic [IdxW-1:0]      dec_idx_d;
    logic                 dec_err_d;

    assign w_pop       = rsp_valid_q & rsp_ready_i;
    assign w_slot_free = ~rsp_valid_q | rsp_ready_i;
    // Gated by reset so no requester sees a grant that the reset discards.
    assign w_can_grant = w_slot_free & (state_q == RUN) & ~rst_i;

    // Round-robin search: first valid requester at or after rr_q.
    always_comb begin : arb
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NoReq; k++) begin
            w_cand = ReqW'((int'(rr_q) + k) % NoReq);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin : grant
        w_grant = '0;
        if (w_can_grant && w_found) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign req_ready_o = w_grant;
    assign rr_d        = (w_winner == ReqW'(NoReq - 1)) ? '0 : w_winner + 1'b1;

    // Ascending scan so the highest-numbered matching rule is the one kept.
    // A rule with start >= end can never satisfy both compares.
    assign w_addr = req_addr_i[w_winner];

    always_comb begin : decode
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int r = 0; r < NoRules; r++) begin
            if ((act_start_q[r] <= w_addr) && (w_addr < act_end_q[r])) begin
                w_hit     = 1'b1;
                w_hit_idx = act_idx_q[r];
            end
        end
    end

`ifdef ADDR_DECODE_SCHED_DEFAULT_IDX_EN
    assign dec_idx_d = w_hit ? w_hit_idx : (en_default_idx_i ? default_idx_i : '0);
    assign dec_err_d = ~w_hit & ~en_default_idx_i;
`else
    assign dec_idx_d = w_hit ? w_hit_idx : '0;
    assign dec_err_d = ~w_hit;

    logic unused_default;
    assign unused_default = ^{en_default_idx_i, default_idx_i};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            cfg_ready_q <= 1'b1;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_req_q   <= '0;
            rsp_idx_q   <= '0;
            rsp_error_q <= 1'b0;
            for (int r = 0; r < NoRules; r++) begin
                shd_start_q[r] <= '0;
                shd_end_q[r]   <= '0;
                shd_idx_q[r]   <= '0;
                act_start_q[r] <= '0;
                act_end_q[r]   <= '0;
                act_idx_q[r]   <= '0;
            end
        end else begin
            // Response slot: a grant refills it (covering a same-cycle pop).
            if (|w_grant) begin
                rsp_valid_q <= 1'b1;
                rsp_req_q   <= w_winner;
                rsp_idx_q   <= dec_idx_d;
                rsp_error_q <= dec_err_d;
                rr_q        <= rr_d;
            end else if (w_pop) begin
                rsp_valid_q <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    // Out-of-range rule numbers match no slot and are dropped.
                    if (cfg_valid_i) begin
                        for (int r = 0; r < NoRules; r++) begin
                            if (cfg_rule_i == RuleW'(r)) begin
                                shd_start_q[r] <= cfg_start_i;
                                shd_end_q[r]   <= cfg_end_i;
                                shd_idx_q[r]   <= cfg_idx_i;
                            end
                        end
                    end
                    if (cfg_commit_i) begin
                        state_q     <= DRAIN;
                        cfg_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Copy only once the in-flight response has left.
                    if (w_slot_free) begin
                        for (int r = 0; r < NoRules; r++) begin
                            act_start_q[r] <= shd_start_q[r];
                            act_end_q[r]   <= shd_end_q[r];
                            act_idx_q[r]   <= shd_idx_q[r];
                        end
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_q     <= RUN;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= RUN;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_req_o   = rsp_req_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_error_o = rsp_error_q;
    assign cfg_ready_o = cfg_ready_q;

endmodule
`default_nettype wire
